// File: rtl/regbank_sb.sv
// regbank_sb: dual-write, multi-read register bank with pending-load scoreboard
module regbank_sb #(
  parameter int REG_WIDTH = 32,
  parameter int REG_COUNT = 16,
  parameter int NUM_RD    = 2,
  parameter int ZERO_REG  = 1,
  localparam int AW = $clog2(REG_COUNT),
  localparam int CW = $clog2(REG_COUNT + 1)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        we0,
  input  logic [AW-1:0]               waddr0,
  input  logic [REG_WIDTH-1:0]        wdata0,
  input  logic                        we1,
  input  logic [AW-1:0]               waddr1,
  input  logic [REG_WIDTH-1:0]        wdata1,
  input  logic [NUM_RD*AW-1:0]        raddr,
  output logic [NUM_RD*REG_WIDTH-1:0] rdata,
  input  logic                        rsv_valid,
  input  logic [AW-1:0]               rsv_addr,
  output logic [NUM_RD-1:0]           hazard,
  output logic [REG_COUNT-1:0]        busy_vec,
  output logic [CW-1:0]               pend_cnt,
  output logic                        wr_conflict,
  output logic                        rsv_err
);
  logic [REG_WIDTH-1:0] mem [REG_COUNT];
  logic w0_ok, w1_ok, rsv_ok, conflict, rsv_err_nxt;
  logic [REG_COUNT-1:0] busy_nxt;
  logic [CW-1:0] cnt_nxt;
  logic [AW-1:0] a;

  function automatic logic live(input logic [AW-1:0] x);
    live = 1'b0;
    for (int r = (ZERO_REG != 0) ? 1 : 0; r < REG_COUNT; r++)
      if (x == AW'(r)) live = 1'b1;
  endfunction

  assign w0_ok    = we0 && live(waddr0);
  assign w1_ok    = we1 && live(waddr1);
  assign rsv_ok   = rsv_valid && live(rsv_addr);
  assign conflict = w0_ok && w1_ok && waddr0 == waddr1;

  // next scoreboard: release by port 1, reservation wins over release, error on re-reserve
  always_comb begin
    busy_nxt = busy_vec;
    rsv_err_nxt = 1'b0;
    cnt_nxt = '0;
    for (int r = 0; r < REG_COUNT; r++) begin
      if (w1_ok && waddr1 == AW'(r)) busy_nxt[r] = 1'b0;
      if (rsv_ok && rsv_addr == AW'(r)) begin
        rsv_err_nxt = busy_vec[r] && !(w1_ok && waddr1 == AW'(r));
        busy_nxt[r] = 1'b1;
      end
    end
    for (int r = 0; r < REG_COUNT; r++) cnt_nxt += CW'(busy_nxt[r]);
  end

  // combinational reads with same-cycle bypass, port 1 taking priority
  always_comb begin
    rdata = '0;
    hazard = '0;
    a = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      a = raddr[i*AW +: AW];
      for (int r = 0; r < REG_COUNT; r++)
        if (a == AW'(r)) begin
          rdata[i*REG_WIDTH +: REG_WIDTH] = mem[r];
          hazard[i] = busy_vec[r];
        end
      if (w1_ok && waddr1 == a) begin
        rdata[i*REG_WIDTH +: REG_WIDTH] = wdata1;
        hazard[i] = 1'b0;
      end else if (w0_ok && waddr0 == a) rdata[i*REG_WIDTH +: REG_WIDTH] = wdata0;
    end
  end

  // storage, busy tracking and one-cycle status pulses
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int r = 0; r < REG_COUNT; r++) mem[r] <= '0;
      busy_vec <= '0;
      pend_cnt <= '0;
      wr_conflict <= 1'b0;
      rsv_err <= 1'b0;
    end else begin
      for (int r = 0; r < REG_COUNT; r++)
        if (w1_ok && waddr1 == AW'(r)) mem[r] <= wdata1;
        else if (w0_ok && waddr0 == AW'(r)) mem[r] <= wdata0;
      busy_vec <= busy_nxt;
      pend_cnt <= cnt_nxt;
      wr_conflict <= conflict;
      rsv_err <= rsv_err_nxt;
    end
  end
endmodule

// File: tb/tb_regbank_sb.sv
// tb_regbank_sb: randomized and directed checks of regbank_sb against an array model
module tb_regbank_sb;
  logic clk = 1'b0;
  logic rst_n, we0, we1, rsv_valid, wr_conflict, rsv_err;
  logic [3:0] waddr0, waddr1, rsv_addr;
  logic [31:0] wdata0, wdata1;
  logic [7:0] raddr;
  logic [63:0] rdata;
  logic [1:0] hazard;
  logic [15:0] busy_vec;
  logic [4:0] pend_cnt;

  logic [31:0] m_mem [16];
  bit m_busy [16];
  bit m_conf, m_err;
  int total = 0, bad = 0;

  regbank_sb dut (
    .clk(clk), .rst_n(rst_n),
    .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
    .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
    .raddr(raddr), .rdata(rdata),
    .rsv_valid(rsv_valid), .rsv_addr(rsv_addr),
    .hazard(hazard), .busy_vec(busy_vec), .pend_cnt(pend_cnt),
    .wr_conflict(wr_conflict), .rsv_err(rsv_err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] exp_rd(input logic [3:0] x);
    if (x == 0) return 32'h0;
    if (we1 && waddr1 == x) return wdata1;
    if (we0 && waddr0 == x) return wdata0;
    return m_mem[x];
  endfunction

  function automatic logic exp_hz(input logic [3:0] x);
    return x != 0 && m_busy[x] && !(we1 && waddr1 == x);
  endfunction

  function automatic logic [15:0] exp_busy();
    logic [15:0] v;
    for (int r = 0; r < 16; r++) v[r] = m_busy[r];
    return v;
  endfunction

  function automatic logic [4:0] exp_cnt();
    int n = 0;
    for (int r = 0; r < 16; r++) n += int'(m_busy[r]);
    return 5'(n);
  endfunction

  task automatic model_edge();
    if (!rst_n) begin
      for (int r = 0; r < 16; r++) begin m_mem[r] = 0; m_busy[r] = 0; end
      m_conf = 0;
      m_err = 0;
    end else begin
      m_conf = we0 && we1 && waddr0 == waddr1 && waddr0 != 0;
      m_err = rsv_valid && rsv_addr != 0 && m_busy[rsv_addr] && !(we1 && waddr1 == rsv_addr);
      if (we0 && waddr0 != 0) m_mem[waddr0] = wdata0;
      if (we1 && waddr1 != 0) begin m_mem[waddr1] = wdata1; m_busy[waddr1] = 0; end
      if (rsv_valid && rsv_addr != 0) m_busy[rsv_addr] = 1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    rst_n = 1; we0 = 0; we1 = 0; rsv_valid = 0;
    waddr0 = 0; waddr1 = 0; rsv_addr = 0; wdata0 = 0; wdata1 = 0;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 0; we0 = 1; waddr0 = 3; wdata0 = $urandom; rsv_valid = 1; rsv_addr = 3;
    tick();
    total++; if (busy_vec !== 16'h0) begin bad++; $display("FAIL reset_busy got %h want 0", busy_vec); end
    total++; if (pend_cnt !== 5'd0) begin bad++; $display("FAIL reset_cnt got %0d want 0", pend_cnt); end
    total++; if (wr_conflict !== 1'b0 || rsv_err !== 1'b0) begin bad++; $display("FAIL reset_pulses got %b%b want 00", wr_conflict, rsv_err); end
    idle();
    raddr = {4'd8, 4'd3};
    @(negedge clk);
    total++; if (rdata !== 64'h0) begin bad++; $display("FAIL reset_rdata got %h want 0", rdata); end
    total++; if (hazard !== 2'b00) begin bad++; $display("FAIL reset_hazard got %b want 00", hazard); end
    tick();
  endtask

  task automatic test_write_read();
    idle(); we0 = 1; waddr0 = 3; wdata0 = 32'hDEADBEEF;
    tick();
    idle(); raddr = {4'd0, 4'd3};
    @(negedge clk);
    total++; if (rdata[31:0] !== 32'hDEADBEEF) begin bad++; $display("FAIL wr_rd got %h want deadbeef", rdata[31:0]); end
    we0 = 1; waddr0 = 3; wdata0 = 32'h12345678;
    @(negedge clk);
    total++; if (rdata[31:0] !== 32'h12345678) begin bad++; $display("FAIL bypass got %h want 12345678", rdata[31:0]); end
    tick();
  endtask

  task automatic test_conflict();
    idle(); we0 = 1; waddr0 = 5; wdata0 = 32'h1111; we1 = 1; waddr1 = 5; wdata1 = 32'h2222;
    tick();
    total++; if (wr_conflict !== 1'b1) begin bad++; $display("FAIL conflict_pulse got %b want 1", wr_conflict); end
    idle(); raddr = {4'd5, 4'd0};
    @(negedge clk);
    total++; if (rdata[63:32] !== 32'h2222) begin bad++; $display("FAIL conflict_data got %h want 2222", rdata[63:32]); end
    tick();
    total++; if (wr_conflict !== 1'b0) begin bad++; $display("FAIL conflict_clear got %b want 0", wr_conflict); end
  endtask

  task automatic test_scoreboard();
    idle(); rsv_valid = 1; rsv_addr = 7;
    tick();
    total++; if (busy_vec[7] !== 1'b1 || pend_cnt !== 5'd1) begin bad++; $display("FAIL rsv_set got %h/%0d want bit7/1", busy_vec, pend_cnt); end
    idle(); raddr = {4'd0, 4'd7};
    @(negedge clk);
    total++; if (hazard[0] !== 1'b1) begin bad++; $display("FAIL hazard_set got %b want 1", hazard[0]); end
    we1 = 1; waddr1 = 7; wdata1 = 32'hABCD0123;
    @(negedge clk);
    total++; if (hazard[0] !== 1'b0 || rdata[31:0] !== 32'hABCD0123) begin bad++; $display("FAIL release_bypass got %b/%h want 0/abcd0123", hazard[0], rdata[31:0]); end
    tick();
    total++; if (busy_vec[7] !== 1'b0 || pend_cnt !== 5'd0) begin bad++; $display("FAIL release got %h/%0d want 0/0", busy_vec, pend_cnt); end
    idle(); rsv_valid = 1; rsv_addr = 7;
    tick();
    tick();
    total++; if (rsv_err !== 1'b1) begin bad++; $display("FAIL rsv_err got %b want 1", rsv_err); end
    idle();
    tick();
    total++; if (rsv_err !== 1'b0) begin bad++; $display("FAIL rsv_err_clear got %b want 0", rsv_err); end
    rsv_valid = 1; rsv_addr = 7; we1 = 1; waddr1 = 7; wdata1 = 32'h5;
    tick();
    total++; if (busy_vec[7] !== 1'b1 || rsv_err !== 1'b0) begin bad++; $display("FAIL set_wins got %b/%b want 1/0", busy_vec[7], rsv_err); end
    idle(); we1 = 1; waddr1 = 7; wdata1 = 32'h6;
    tick();
  endtask

  task automatic test_zero_reg();
    idle(); we0 = 1; waddr0 = 0; wdata0 = 32'hFFFF; we1 = 1; waddr1 = 0; wdata1 = 32'hFFFF;
    rsv_valid = 1; rsv_addr = 0; raddr = 8'h00;
    @(negedge clk);
    total++; if (rdata !== 64'h0 || hazard !== 2'b00) begin bad++; $display("FAIL zero_read got %h/%b want 0/00", rdata, hazard); end
    tick();
    total++; if (busy_vec !== 16'h0 || wr_conflict !== 1'b0 || rsv_err !== 1'b0) begin bad++; $display("FAIL zero_state got %h/%b/%b want 0/0/0", busy_vec, wr_conflict, rsv_err); end
    idle();
    @(negedge clk);
    total++; if (rdata !== 64'h0) begin bad++; $display("FAIL zero_stored got %h want 0", rdata); end
    tick();
  endtask

  task automatic test_reset_mid();
    idle(); we0 = 1; waddr0 = 9; wdata0 = 32'h77;
    tick();
    idle();
    rsv_valid = 1;
    rsv_addr = 2; tick();
    rsv_addr = 4; tick();
    rsv_addr = 9; tick();
    total++; if (pend_cnt !== 5'd3) begin bad++; $display("FAIL mid_cnt got %0d want 3", pend_cnt); end
    rst_n = 0; rsv_addr = 2;
    tick();
    total++; if (busy_vec !== 16'h0 || pend_cnt !== 5'd0 || rsv_err !== 1'b0 || wr_conflict !== 1'b0) begin bad++; $display("FAIL mid_reset got %h/%0d/%b/%b want 0/0/0/0", busy_vec, pend_cnt, rsv_err, wr_conflict); end
    idle(); raddr = {4'd4, 4'd9};
    @(negedge clk);
    total++; if (rdata !== 64'h0 || hazard !== 2'b00) begin bad++; $display("FAIL mid_read got %h/%b want 0/00", rdata, hazard); end
    tick();
    total++; if (rsv_err !== 1'b0 || wr_conflict !== 1'b0) begin bad++; $display("FAIL mid_pulse got %b/%b want 0/0", rsv_err, wr_conflict); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      rst_n = $urandom_range(0, 59) != 0;
      we0 = $urandom_range(0, 1); we1 = $urandom_range(0, 1); rsv_valid = $urandom_range(0, 2) == 0;
      waddr0 = 4'($urandom_range(0, 15)); waddr1 = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) waddr1 = waddr0;
      rsv_addr = $urandom_range(0, 2) == 0 ? waddr1 : 4'($urandom_range(0, 15));
      wdata0 = $urandom; wdata1 = $urandom;
      raddr[3:0] = $urandom_range(0, 2) == 0 ? waddr1 : 4'($urandom_range(0, 15));
      raddr[7:4] = $urandom_range(0, 2) == 0 ? waddr0 : 4'($urandom_range(0, 15));
      @(negedge clk);
      total++; if (rdata[31:0] !== exp_rd(raddr[3:0])) begin bad++; $display("FAIL rnd_rd0 n=%0d got %h want %h", n, rdata[31:0], exp_rd(raddr[3:0])); end
      total++; if (rdata[63:32] !== exp_rd(raddr[7:4])) begin bad++; $display("FAIL rnd_rd1 n=%0d got %h want %h", n, rdata[63:32], exp_rd(raddr[7:4])); end
      total++; if (hazard !== {exp_hz(raddr[7:4]), exp_hz(raddr[3:0])}) begin bad++; $display("FAIL rnd_hazard n=%0d got %b want %b", n, hazard, {exp_hz(raddr[7:4]), exp_hz(raddr[3:0])}); end
      tick();
      total++; if (busy_vec !== exp_busy()) begin bad++; $display("FAIL rnd_busy n=%0d got %h want %h", n, busy_vec, exp_busy()); end
      total++; if (pend_cnt !== exp_cnt()) begin bad++; $display("FAIL rnd_cnt n=%0d got %0d want %0d", n, pend_cnt, exp_cnt()); end
      total++; if (wr_conflict !== m_conf || rsv_err !== m_err) begin bad++; $display("FAIL rnd_pulse n=%0d got %b%b want %b%b", n, wr_conflict, rsv_err, m_conf, m_err); end
    end
  endtask

  initial begin
    idle();
    raddr = 0;
    rst_n = 0;
    for (int r = 0; r < 16; r++) begin m_mem[r] = 0; m_busy[r] = 0; end
    m_conf = 0;
    m_err = 0;
    @(posedge clk);
    #1;
    test_reset();
    test_write_read();
    test_conflict();
    test_scoreboard();
    test_zero_reg();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/regbank_sb.md
REGBANK_SB -- requirements
Module: regbank_sb

Interface
REQ-001 SHALL have parameter REG_WIDTH, default 32, data width of each register.
REQ-002 SHALL have parameter REG_COUNT, default 16, number of registers; AW = $clog2(REG_COUNT).
REQ-003 SHALL have parameter NUM_RD, default 2, number of independent read ports (1..4).
REQ-004 SHALL have parameter ZERO_REG, default 1, when 1 register 0 is hardwired to zero.
REQ-005 SHALL use one clock; reset is synchronous and active-low.
REQ-006 clk  input  1  rising-edge clock for all state.
REQ-007 rst_n  input  1  synchronous active-low reset.
REQ-008 we0 / waddr0 / wdata0  input  1 / AW / REG_WIDTH  write port 0 (ALU result).
REQ-009 we1 / waddr1 / wdata1  input  1 / AW / REG_WIDTH  write port 1 (long-latency return, e.g. SPI load).
REQ-010 raddr  input  NUM_RD*AW  packed read addresses, port i at bits [i*AW +: AW].
REQ-011 rdata  output  NUM_RD*REG_WIDTH  packed read data, port i at [i*REG_WIDTH +: REG_WIDTH].
REQ-012 rsv_valid / rsv_addr  input  1 / AW  reserve register as pending on a long-latency op.
REQ-013 hazard  output  NUM_RD  per read port: addressed register pending and not resolvable this cycle.
REQ-014 busy_vec  output  REG_COUNT  registered pending bit per register.
REQ-015 pend_cnt  output  $clog2(REG_COUNT+1)  registered count of set busy bits.
REQ-016 wr_conflict  output  1  registered one-cycle pulse: both write ports hit the same address.
REQ-017 rsv_err  output  1  registered one-cycle pulse: reservation of an already-busy register.

Function
REQ-018 Writes SHALL commit at the rising edge when the port's we is 1; both ports may write different registers in the same cycle.
REQ-019 Same-address dual write: port 1 data SHALL be stored, port 0 discarded; wr_conflict = 1 the following cycle.
REQ-020 Reads SHALL be combinational; rdata[i] = stored value of raddr[i], with same-cycle bypass: matching we1 -> wdata1, else matching we0 -> wdata0.
REQ-021 ZERO_REG=1: address 0 SHALL read 0, writes to it SHALL be ignored (no wr_conflict), reservations ignored (no busy, no rsv_err).
REQ-022 rsv_valid=1 SHALL set busy_vec[rsv_addr] at the next edge.
REQ-023 A port-1 write SHALL clear busy_vec[waddr1] at the edge; port-0 writes SHALL NOT change busy.
REQ-024 Simultaneous reserve and port-1 release of the same address: set SHALL win (busy stays 1, rsv_err = 0).
REQ-025 Reserve of a register already busy and not released that cycle: busy stays 1, rsv_err = 1 next cycle.
REQ-026 hazard[i] = busy_vec[raddr[i]] AND NOT (we1 AND waddr1 == raddr[i]); combinational; 0 for address 0 when ZERO_REG=1.
REQ-027 pend_cnt SHALL equal popcount(busy_vec) at every cycle, updated in the same edge as busy_vec; no overflow is possible.
REQ-028 Out-of-range addresses (>= REG_COUNT when not a power of two) SHALL be ignored on write/reserve and read as 0.

Reset
REQ-029 With rst_n = 0 at an edge: all registers = 0, busy_vec = 0, pend_cnt = 0, wr_conflict = 0, rsv_err = 0.
REQ-030 Reset SHALL dominate same-cycle writes and reservations; rdata/hazard follow the cleared state combinationally after the edge.
REQ-031 Reset mid-operation SHALL drop all pending reservations without any error pulse.

Verification
REQ-032 Write r3=0xDEADBEEF via port 0, next cycle raddr0=3 -> rdata0=0xDEADBEEF; same-cycle read of r3 while writing 0x12345678 -> 0x12345678.
REQ-033 we0/we1 both to r5 with 0x1111/0x2222 -> r5=0x2222, wr_conflict=1 for exactly one cycle.
REQ-034 Reserve r7 -> busy_vec[7]=1, pend_cnt=1, read r7 gives hazard=1; we1 to r7 in cycle N -> hazard=0 in cycle N with bypassed data, busy cleared, pend_cnt=0 after edge.
REQ-035 Reserve r7 while busy -> rsv_err pulse; reserve+release r7 same cycle -> busy stays 1, no rsv_err.
REQ-036 ZERO_REG=1: write 0xFFFF to r0 and reserve r0 -> read r0=0, busy_vec=0, hazard=0.
REQ-037 Reserve r2, r4, r9, assert rst_n=0 one cycle -> all registers 0, busy_vec=0, pend_cnt=0, no pulses.
